instr_dec_q: RTL

- Next-generation MSP430 instruction decoder.
- Accepts a stream of 16-bit words from the ROM/MDB fetch path with a valid/ready handshake.
- Decodes each opcode word and collects its 0..2 extension words (source first, then destination). Handles constant-generator sources, which need no extension word.
- Pushes one complete decoded bundle into a QDEPTH-entry output queue, which feeds the register file, ALU FS select and PC/SR mux control.

---
 rtl/msp430_ops.sv | 65 ++++++
 rtl/instr_fifo.sv | 55 +++++
 rtl/instr_dec_q.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/msp430_ops.sv
// Shared MSP430 decode constants: formats, FS codes, opcodes, FSM states,
// constant-generator values and the decoded bundle layout.
package msp430_ops;

  localparam logic [1:0] FMT_ILL = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_II  = 2'd2;
  localparam logic [1:0] FMT_JMP = 2'd3;

  localparam logic [1:0] S_OP  = 2'd0;
  localparam logic [1:0] S_SRC = 2'd1;
  localparam logic [1:0] S_DST = 2'd2;

  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h9;
  localparam logic [3:0] OP_BIT = 4'hB;
  localparam logic [3:0] OP_BIC = 4'hC;
  localparam logic [3:0] OP_BIS = 4'hD;

  localparam logic [2:0] OP2_SWPB = 3'd1;
  localparam logic [2:0] OP2_PUSH = 3'd4;
  localparam logic [2:0] OP2_CALL = 3'd5;
  localparam logic [2:0] OP2_BAD  = 3'd7;

  localparam logic [15:0] CG_R2_AS10 = 16'h0004;
  localparam logic [15:0] CG_R2_AS11 = 16'h0008;
  localparam logic [15:0] CG_R3_AS00 = 16'h0000;
  localparam logic [15:0] CG_R3_AS01 = 16'h0001;
  localparam logic [15:0] CG_R3_AS10 = 16'h0002;
  localparam logic [15:0] CG_R3_AS11 = 16'hFFFF;

  // FS layout: format I = {01, opcode}, format II = {100, sub-op}, jump = {000, cond}
  function automatic logic [5:0] fs_fmt1(input logic [3:0] op);
    return {2'b01, op};
  endfunction

  function automatic logic [5:0] fs_fmt2(input logic [2:0] sub);
    return {3'b100, sub};
  endfunction

  function automatic logic [5:0] fs_jmp(input logic [2:0] cond);
    return {3'b000, cond};
  endfunction

  typedef struct packed {
    logic [1:0]  format;
    logic [5:0]  fs;
    logic        rw;
    logic        sr_we;
    logic        bw;
    logic [3:0]  sa;
    logic [3:0]  da;
    logic [1:0]  src_as;
    logic        ad;
    logic [9:0]  jmp_off;
    logic        src_has_ext;
    logic        dst_has_ext;
    logic [15:0] src_ext;
    logic [15:0] dst_ext;
    logic        cg_en;
    logic [15:0] cg_val;
    logic        illegal;
  } bundle_t;

endpackage

// File: rtl/instr_fifo.sv
// Width/depth-parametric FIFO with occupancy count; head reads zero when empty.
module instr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // A pop in the same cycle frees a slot, so a push onto a full FIFO is legal then.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

  assign dout = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_dec_q.sv
// MSP430 instruction decoder: gathers opcode plus 0..2 extension words and
// queues one decoded bundle per instruction for the execute stage.
module instr_dec_q
  import msp430_ops::*;
#(
  parameter int WORD_W = 16,
  parameter int QDEPTH = 2,
  parameter int CG_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_format,
  output logic [5:0]        out_fs,
  output logic              out_rw,
  output logic              out_sr_we,
  output logic              out_bw,
  output logic [3:0]        out_sa,
  output logic [3:0]        out_da,
  output logic [1:0]        out_as,
  output logic              out_ad,
  output logic [9:0]        out_jmp_off,
  output logic              out_src_has_ext,
  output logic              out_dst_has_ext,
  output logic [WORD_W-1:0] out_src_ext,
  output logic [WORD_W-1:0] out_dst_ext,
  output logic              out_cg_en,
  output logic [WORD_W-1:0] out_cg_val,
  output logic              out_illegal
);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  generate
    if (WORD_W != 16) begin : g_bad_word_w
      $error("instr_dec_q: WORD_W must be 16");
    end
    if (QDEPTH < 1 || QDEPTH > 8) begin : g_bad_qdepth
      $error("instr_dec_q: QDEPTH must be 1..8");
    end
  endgenerate

  logic [1:0]    state;
  bundle_t       dec, part, push_data, head;
  logic          need_src, need_dst, part_need_dst;
  logic [CW-1:0] count;
  logic          accept, push, pop, last_word;
  logic          is_jmp, is_f1, is_f2, cg_hit;
  logic [3:0]    src_reg;
  logic [1:0]    src_as;
  logic [15:0]   cg_val;

  assign in_ready  = !flush && !((count == FULL_CNT) && !out_ready);
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  // Opcode-word decode, only meaningful while the FSM is in S_OP
  always_comb begin
    is_jmp  = (in_word[15:13] == 3'b001);
    is_f2   = (in_word[15:10] == 6'b000100) && (in_word[9:7] != OP2_BAD);
    is_f1   = (in_word[15:12] >= 4'h4);
    src_reg = is_f1 ? in_word[11:8] : in_word[3:0];
    src_as  = in_word[5:4];
    cg_hit  = (CG_EN != 0) && (((src_reg == 4'd2) && src_as[1]) || (src_reg == 4'd3));
    if (src_reg == 4'd2) cg_val = src_as[0] ? CG_R2_AS11 : CG_R2_AS10;
    else begin
      case (src_as)
        2'b00:   cg_val = CG_R3_AS00;
        2'b01:   cg_val = CG_R3_AS01;
        2'b10:   cg_val = CG_R3_AS10;
        default: cg_val = CG_R3_AS11;
      endcase
    end
    dec      = '0;
    need_src = 1'b0;
    need_dst = 1'b0;
    if (is_jmp) begin
      dec.format  = FMT_JMP;
      dec.fs      = fs_jmp(in_word[12:10]);
      dec.jmp_off = in_word[9:0];
    end else if (is_f1 || is_f2) begin
      dec.format = is_f1 ? FMT_I : FMT_II;
      dec.bw     = in_word[6];
      dec.sa     = src_reg;
      dec.da     = in_word[3:0];
      dec.src_as = src_as;
      dec.cg_en  = cg_hit;
      dec.cg_val = cg_hit ? cg_val : '0;
      need_src   = !cg_hit && ((src_as == 2'b01) || ((src_as == 2'b11) && (src_reg == 4'd0)));
      need_dst   = is_f1 && in_word[7];
      dec.ad          = need_dst;
      dec.src_has_ext = need_src;
      dec.dst_has_ext = need_dst;
      if (is_f1) begin
        dec.fs = fs_fmt1(in_word[15:12]);
        case (in_word[15:12])
          OP_MOV, OP_BIC, OP_BIS: begin dec.rw = 1'b1; dec.sr_we = 1'b0; end
          OP_CMP, OP_BIT:         begin dec.rw = 1'b0; dec.sr_we = 1'b1; end
          default:                begin dec.rw = 1'b1; dec.sr_we = 1'b1; end
        endcase
      end else begin
        dec.fs = fs_fmt2(in_word[9:7]);
        case (in_word[9:7])
          OP2_SWPB, OP2_PUSH, OP2_CALL: begin dec.rw = 1'b1; dec.sr_we = 1'b0; end
          default:                      begin dec.rw = 1'b1; dec.sr_we = 1'b1; end
        endcase
      end
    end else begin
      dec.illegal = 1'b1;
    end
  end

  // Bundle completion: merge the arriving extension word into the held partial
  always_comb begin
    push_data = dec;
    last_word = 1'b0;
    case (state)
      S_OP:  last_word = !need_src && !need_dst;
      S_SRC: begin
        push_data         = part;
        push_data.src_ext = in_word;
        last_word         = !part_need_dst;
      end
      S_DST: begin
        push_data         = part;
        push_data.dst_ext = in_word;
        last_word         = 1'b1;
      end
      default: last_word = 1'b0;
    endcase
  end

  assign push = accept && last_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_OP;
    else if (flush) state <= S_OP;
    else if (accept) begin
      case (state)
        S_OP:    state <= need_src ? S_SRC : (need_dst ? S_DST : S_OP);
        S_SRC:   state <= part_need_dst ? S_DST : S_OP;
        default: state <= S_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (state == S_OP) begin
        part          <= dec;
        part_need_dst <= need_dst;
      end else if (state == S_SRC) begin
        part.src_ext <= in_word;
      end
    end
  end

  instr_fifo #(
    .W     ($bits(bundle_t)),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  assign out_format      = head.format;
  assign out_fs          = head.fs;
  assign out_rw          = head.rw;
  assign out_sr_we       = head.sr_we;
  assign out_bw          = head.bw;
  assign out_sa          = head.sa;
  assign out_da          = head.da;
  assign out_as          = head.src_as;
  assign out_ad          = head.ad;
  assign out_jmp_off     = head.jmp_off;
  assign out_src_has_ext = head.src_has_ext;
  assign out_dst_has_ext = head.dst_has_ext;
  assign out_src_ext     = head.src_ext;
  assign out_dst_ext     = head.dst_ext;
  assign out_cg_en       = head.cg_en;
  assign out_cg_val      = head.cg_val;
  assign out_illegal     = head.illegal;

endmodule
